// File: rtl/tiny16_loader_pkg.sv
// Shared types and constants for the tiny16 serial program loader.
// Optional inter-byte timeout is enabled by defining TINY16_LOADER_TIMEOUT_EN.
package tiny16_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_CHECK
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Frame layout: SYNC, LEN_HI, LEN_LO, N x {hi, lo}, CHK.
    localparam int FRAME_HDR_BYTES      = 3;
    localparam int FRAME_BYTES_PER_WORD = 2;
    localparam int FRAME_TRAILER_BYTES  = 1;
    localparam bit WORD_HI_FIRST        = 1'b1;

    function automatic logic [15:0] join_word(input logic [7:0] first, input logic [7:0] second);
        return WORD_HI_FIRST ? {first, second} : {second, first};
    endfunction

endpackage

// File: rtl/tiny16_uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling, start-glitch
// rejection and stop-bit framing check. One-cycle byte_valid / frame_err pulses.
module tiny16_uart_rx
    import tiny16_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       srst,
    input  logic       rx,
    output logic [7:0] data_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 4) begin : g_cpb_check
        $error("tiny16_uart_rx: CLKS_PER_BIT must be at least 4");
    end

    logic             rx_meta_reg, rx_sync_reg, rx_prev_reg;
    rx_state_t        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       bit_reg, bit_next;
    logic [7:0]       shift_reg, shift_next;
    logic             valid_reg, valid_next;
    logic             ferr_reg, ferr_next;

    always_ff @(posedge clk) begin
        if (srst) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
            rx_prev_reg <= 1'b1;
            state_reg   <= RX_IDLE;
            cnt_reg     <= '0;
            bit_reg     <= '0;
            shift_reg   <= '0;
            valid_reg   <= 1'b0;
            ferr_reg    <= 1'b0;
        end else begin
            rx_meta_reg <= rx;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_reg     <= bit_next;
            shift_reg   <= shift_next;
            valid_reg   <= valid_next;
            ferr_reg    <= ferr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        valid_next = 1'b0;
        ferr_next  = 1'b0;
        case (state_reg)
            RX_IDLE: begin
                if (rx_prev_reg && !rx_sync_reg) begin
                    state_next = RX_START;
                    cnt_next   = '0;
                end
            end
            RX_START: begin
                if (cnt_reg == HALF_CNT) begin
                    cnt_next = '0;
                    // A start bit that is high again at mid-bit was only a glitch.
                    if (rx_sync_reg) begin
                        state_next = RX_IDLE;
                    end else begin
                        state_next = RX_DATA;
                        bit_next   = '0;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_reg == FULL_CNT) begin
                    cnt_next   = '0;
                    shift_next = {rx_sync_reg, shift_reg[7:1]};
                    if (bit_reg == 3'd7) begin
                        state_next = RX_STOP;
                    end else begin
                        bit_next = bit_reg + 3'd1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_reg == FULL_CNT) begin
                    cnt_next   = '0;
                    state_next = RX_IDLE;
                    if (rx_sync_reg) begin
                        valid_next = 1'b1;
                    end else begin
                        ferr_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

    assign data_byte  = shift_reg;
    assign byte_valid = valid_reg;
    assign frame_err  = ferr_reg;

endmodule

// File: rtl/tiny16_loader.sv
// Serial program loader: receives a framed image over UART, writes it to program
// memory from address 0 and releases CPU_RST only after a good checksum.
// Define TINY16_LOADER_TIMEOUT_EN to abort a load after TIMEOUT_CYCLES of silence.
module tiny16_loader
    import tiny16_loader_pkg::*;
#(
    parameter int         CLKS_PER_BIT   = 104,
    parameter int         ADDR_W         = 16,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RX,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [15:0]       MEM_DATA,
    output logic              CPU_RST,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR
);

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
        $error("tiny16_loader: TIMEOUT_CYCLES must be positive");
    end

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ferr;

    tiny16_uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (CLK),
        .srst      (RST),
        .rx        (RX),
        .data_byte (rx_byte),
        .byte_valid(rx_valid),
        .frame_err (rx_ferr)
    );

    loader_state_t     state_reg, state_next;
    logic [15:0]       len_reg, len_next;
    logic [15:0]       idx_reg, idx_next;
    logic [7:0]        hi_reg, hi_next;
    logic [7:0]        chk_reg, chk_next;
    logic              mem_we_reg, mem_we_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [15:0]       mem_data_reg, mem_data_next;
    logic              cpu_rst_reg, cpu_rst_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;

`ifdef TINY16_LOADER_TIMEOUT_EN
    logic [31:0] tmo_cnt_reg, tmo_cnt_next;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= ST_IDLE;
            len_reg      <= '0;
            idx_reg      <= '0;
            hi_reg       <= '0;
            chk_reg      <= '0;
            mem_we_reg   <= 1'b0;
            mem_addr_reg <= '0;
            mem_data_reg <= '0;
            cpu_rst_reg  <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
`ifdef TINY16_LOADER_TIMEOUT_EN
            tmo_cnt_reg  <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            len_reg      <= len_next;
            idx_reg      <= idx_next;
            hi_reg       <= hi_next;
            chk_reg      <= chk_next;
            mem_we_reg   <= mem_we_next;
            mem_addr_reg <= mem_addr_next;
            mem_data_reg <= mem_data_next;
            cpu_rst_reg  <= cpu_rst_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
`ifdef TINY16_LOADER_TIMEOUT_EN
            tmo_cnt_reg  <= tmo_cnt_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        len_next      = len_reg;
        idx_next      = idx_reg;
        hi_next       = hi_reg;
        chk_next      = chk_reg;
        mem_we_next   = 1'b0;
        mem_addr_next = mem_addr_reg;
        mem_data_next = mem_data_reg;
        cpu_rst_next  = cpu_rst_reg;
        busy_next     = busy_reg;
        done_next     = done_reg;
        err_next      = err_reg;

        if (state_reg != ST_IDLE && rx_ferr) begin
            state_next   = ST_IDLE;
            err_next     = 1'b1;
            busy_next    = 1'b0;
            cpu_rst_next = 1'b1;
        end else if (rx_valid) begin
            case (state_reg)
                ST_IDLE: begin
                    if (rx_byte == SYNC_BYTE) begin
                        state_next   = ST_LEN_HI;
                        cpu_rst_next = 1'b1;
                        busy_next    = 1'b1;
                        done_next    = 1'b0;
                        err_next     = 1'b0;
                        chk_next     = '0;
                        idx_next     = '0;
                    end
                end
                ST_LEN_HI: begin
                    len_next[15:8] = rx_byte;
                    state_next     = ST_LEN_LO;
                end
                ST_LEN_LO: begin
                    len_next[7:0] = rx_byte;
                    state_next    = ({len_reg[15:8], rx_byte} == 16'd0) ? ST_CHECK : ST_DATA_HI;
                end
                ST_DATA_HI: begin
                    hi_next    = rx_byte;
                    chk_next   = chk_reg ^ rx_byte;
                    state_next = ST_DATA_LO;
                end
                ST_DATA_LO: begin
                    mem_we_next   = 1'b1;
                    mem_addr_next = ADDR_W'(idx_reg);
                    mem_data_next = join_word(hi_reg, rx_byte);
                    chk_next      = chk_reg ^ rx_byte;
                    idx_next      = idx_reg + 16'd1;
                    state_next    = (idx_reg + 16'd1 == len_reg) ? ST_CHECK : ST_DATA_HI;
                end
                ST_CHECK: begin
                    if (rx_byte == chk_reg) begin
                        done_next    = 1'b1;
                        cpu_rst_next = 1'b0;
                    end else begin
                        err_next = 1'b1;
                    end
                    busy_next  = 1'b0;
                    state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end

`ifdef TINY16_LOADER_TIMEOUT_EN
        // Counter restarts on every received byte and only runs mid-load.
        tmo_cnt_next = (rx_valid || !busy_reg) ? 32'd0 : tmo_cnt_reg + 32'd1;
        if (busy_reg && !rx_valid && !rx_ferr && tmo_cnt_reg == 32'(TIMEOUT_CYCLES - 1)) begin
            state_next   = ST_IDLE;
            err_next     = 1'b1;
            busy_next    = 1'b0;
            cpu_rst_next = 1'b1;
            tmo_cnt_next = 32'd0;
        end
`endif
    end

    assign MEM_WE   = mem_we_reg;
    assign MEM_ADDR = mem_addr_reg;
    assign MEM_DATA = mem_data_reg;
    assign CPU_RST  = cpu_rst_reg;
    assign BUSY     = busy_reg;
    assign DONE     = done_reg;
    assign ERR      = err_reg;

endmodule

// File: tb/tb_tiny16_loader.sv
// Self-checking bench for tiny16_loader: UART byte driver, write monitor and a
// frame-level reference model (expected writes and checksum from the words sent).
module tb_tiny16_loader;

    localparam int CPB = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        RX  = 1'b1;
    logic        MEM_WE;
    logic [15:0] MEM_ADDR;
    logic [15:0] MEM_DATA;
    logic        CPU_RST, BUSY, DONE, ERR;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    logic [15:0] model_words[$];
    logic [7:0]  frame_q[$];

    tiny16_loader #(
        .CLKS_PER_BIT  (CPB),
        .ADDR_W        (16),
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(200)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .RX      (RX),
        .MEM_WE  (MEM_WE),
        .MEM_ADDR(MEM_ADDR),
        .MEM_DATA(MEM_DATA),
        .CPU_RST (CPU_RST),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .ERR     (ERR)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (MEM_WE) begin
            wr_addr_q.push_back(MEM_ADDR);
            wr_data_q.push_back(MEM_DATA);
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit bad_stop, input int gap_bits);
        RX = 1'b0;
        repeat (CPB) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (CPB) @(negedge CLK);
        end
        RX = bad_stop ? 1'b0 : 1'b1;
        repeat (CPB) @(negedge CLK);
        RX = 1'b1;
        repeat (gap_bits * CPB) @(negedge CLK);
    endtask

    // Reference model: random words, frame bytes, checksum = XOR of data bytes.
    task automatic make_frame(input int n, input bit corrupt);
        logic [7:0] chk;
        logic [15:0] w;
        model_words.delete();
        frame_q.delete();
        chk = 8'h00;
        frame_q.push_back(8'hA5);
        frame_q.push_back(n[15:8]);
        frame_q.push_back(n[7:0]);
        for (int i = 0; i < n; i++) begin
            w = 16'($urandom);
            model_words.push_back(w);
            frame_q.push_back(w[15:8]);
            frame_q.push_back(w[7:0]);
            chk = chk ^ w[15:8] ^ w[7:0];
        end
        if (corrupt) chk = chk ^ 8'(1 + $urandom_range(0, 254));
        frame_q.push_back(chk);
    endtask

    task automatic send_frame();
        foreach (frame_q[i]) send_byte(frame_q[i], 1'b0, $urandom_range(0, 2));
        repeat (8) @(negedge CLK);
    endtask

    task automatic clear_writes();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        n_cmp += 7;
        if (MEM_WE !== 1'b0)    begin n_bad++; $display("FAIL reset_we got=%b want=0", MEM_WE); end
        if (MEM_ADDR !== 16'h0) begin n_bad++; $display("FAIL reset_addr got=%h want=0", MEM_ADDR); end
        if (MEM_DATA !== 16'h0) begin n_bad++; $display("FAIL reset_data got=%h want=0", MEM_DATA); end
        if (CPU_RST !== 1'b1)   begin n_bad++; $display("FAIL reset_cpu_rst got=%b want=1", CPU_RST); end
        if (BUSY !== 1'b0)      begin n_bad++; $display("FAIL reset_busy got=%b want=0", BUSY); end
        if (DONE !== 1'b0)      begin n_bad++; $display("FAIL reset_done got=%b want=0", DONE); end
        if (ERR !== 1'b0)       begin n_bad++; $display("FAIL reset_err got=%b want=0", ERR); end
        RST = 1'b0;
        repeat (4) @(negedge CLK);
        $display("reset: outputs checked");
    endtask

    task automatic test_directed_stream(input logic [7:0] chk_byte, input bit exp_ok);
        logic [7:0]  s[12];
        logic [15:0] exp_w[4];
        s = '{8'hA5, 8'h00, 8'h04, 8'h15, 8'h01, 8'h17, 8'h02, 8'h34, 8'h30, 8'hC0, 8'h03, 8'h00};
        s[11] = chk_byte;
        exp_w = '{16'h1501, 16'h1702, 16'h3430, 16'hC003};
        clear_writes();
        foreach (s[i]) send_byte(s[i], 1'b0, 0);
        repeat (8) @(negedge CLK);
        n_cmp++;
        if (wr_addr_q.size() != 4) begin n_bad++; $display("FAIL dir_wr_count got=%0d want=4", wr_addr_q.size()); end
        for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
            n_cmp += 2;
            if (wr_addr_q[i] !== 16'(i))  begin n_bad++; $display("FAIL dir_addr[%0d] got=%h want=%h", i, wr_addr_q[i], i); end
            if (wr_data_q[i] !== exp_w[i]) begin n_bad++; $display("FAIL dir_data[%0d] got=%h want=%h", i, wr_data_q[i], exp_w[i]); end
        end
        n_cmp += 4;
        if (DONE !== exp_ok)     begin n_bad++; $display("FAIL dir_done got=%b want=%b", DONE, exp_ok); end
        if (ERR !== !exp_ok)     begin n_bad++; $display("FAIL dir_err got=%b want=%b", ERR, !exp_ok); end
        if (CPU_RST !== !exp_ok) begin n_bad++; $display("FAIL dir_cpu_rst got=%b want=%b", CPU_RST, !exp_ok); end
        if (BUSY !== 1'b0)       begin n_bad++; $display("FAIL dir_busy got=%b want=0", BUSY); end
        $display("directed stream chk=%h writes=%0d done=%b err=%b", chk_byte, wr_addr_q.size(), DONE, ERR);
    endtask

    task automatic test_zero_len(input logic [7:0] chk_byte, input bit exp_ok);
        clear_writes();
        send_byte(8'hA5, 1'b0, 1);
        send_byte(8'h00, 1'b0, 0);
        send_byte(8'h00, 1'b0, 0);
        send_byte(chk_byte, 1'b0, 0);
        repeat (8) @(negedge CLK);
        n_cmp += 4;
        if (wr_addr_q.size() != 0) begin n_bad++; $display("FAIL zero_wr_count got=%0d want=0", wr_addr_q.size()); end
        if (DONE !== exp_ok)       begin n_bad++; $display("FAIL zero_done got=%b want=%b", DONE, exp_ok); end
        if (ERR !== !exp_ok)       begin n_bad++; $display("FAIL zero_err got=%b want=%b", ERR, !exp_ok); end
        if (CPU_RST !== !exp_ok)   begin n_bad++; $display("FAIL zero_cpu_rst got=%b want=%b", CPU_RST, !exp_ok); end
        $display("zero-length frame chk=%h done=%b err=%b", chk_byte, DONE, ERR);
    endtask

    task automatic test_random_frames();
        int  n;
        bit  corrupt;
        logic [7:0] g;
        for (int f = 0; f < 6; f++) begin
            n = $urandom_range(1, 6);
            corrupt = ($urandom_range(0, 2) == 0);
            for (int k = $urandom_range(0, 2); k > 0; k--) begin
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h5A;
                send_byte(g, 1'b0, 1);
            end
            make_frame(n, corrupt);
            clear_writes();
            send_frame();
            n_cmp++;
            if (wr_addr_q.size() != n) begin n_bad++; $display("FAIL rnd_wr_count got=%0d want=%0d", wr_addr_q.size(), n); end
            for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
                n_cmp += 2;
                if (wr_addr_q[i] !== 16'(i)) begin n_bad++; $display("FAIL rnd_addr[%0d] got=%h want=%h", i, wr_addr_q[i], i); end
                if (wr_data_q[i] !== model_words[i]) begin n_bad++; $display("FAIL rnd_data[%0d] got=%h want=%h", i, wr_data_q[i], model_words[i]); end
            end
            n_cmp += 3;
            if (DONE !== !corrupt)   begin n_bad++; $display("FAIL rnd_done got=%b want=%b", DONE, !corrupt); end
            if (ERR !== corrupt)     begin n_bad++; $display("FAIL rnd_err got=%b want=%b", ERR, corrupt); end
            if (CPU_RST !== corrupt) begin n_bad++; $display("FAIL rnd_cpu_rst got=%b want=%b", CPU_RST, corrupt); end
            $display("random frame %0d: n=%0d corrupt=%0d done=%b err=%b", f, n, corrupt, DONE, ERR);
        end
    endtask

    task automatic test_framing_error();
        logic [7:0] g;
        make_frame(4, 1'b0);
        clear_writes();
        for (int i = 0; i < 5; i++) send_byte(frame_q[i], 1'b0, 0);
        send_byte(frame_q[5], 1'b1, 2);
        repeat (8) @(negedge CLK);
        n_cmp += 6;
        if (wr_addr_q.size() != 1) begin n_bad++; $display("FAIL ferr_wr_count got=%0d want=1", wr_addr_q.size()); end
        else if (wr_addr_q[0] !== 16'h0 || wr_data_q[0] !== model_words[0])
            begin n_bad++; $display("FAIL ferr_write0 got=%h/%h want=0000/%h", wr_addr_q[0], wr_data_q[0], model_words[0]); end
        if (ERR !== 1'b1)     begin n_bad++; $display("FAIL ferr_err got=%b want=1", ERR); end
        if (BUSY !== 1'b0)    begin n_bad++; $display("FAIL ferr_busy got=%b want=0", BUSY); end
        if (CPU_RST !== 1'b1) begin n_bad++; $display("FAIL ferr_cpu_rst got=%b want=1", CPU_RST); end
        if (DONE !== 1'b0)    begin n_bad++; $display("FAIL ferr_done got=%b want=0", DONE); end
        $display("framing error mid-load: writes=%0d err=%b", wr_addr_q.size(), ERR);
        for (int k = 0; k < 3; k++) begin
            g = 8'($urandom);
            if (g == 8'hA5) g = 8'h00;
            send_byte(g, 1'b0, 1);
        end
        make_frame(3, 1'b0);
        clear_writes();
        send_frame();
        n_cmp += 3;
        if (wr_addr_q.size() != 3) begin n_bad++; $display("FAIL ferr_reload_count got=%0d want=3", wr_addr_q.size()); end
        if (DONE !== 1'b1)    begin n_bad++; $display("FAIL ferr_reload_done got=%b want=1", DONE); end
        if (CPU_RST !== 1'b0) begin n_bad++; $display("FAIL ferr_reload_cpu_rst got=%b want=0", CPU_RST); end
        $display("reload after garbage: writes=%0d done=%b", wr_addr_q.size(), DONE);
    endtask

    task automatic test_rst_midload();
        make_frame(4, 1'b0);
        clear_writes();
        for (int i = 0; i < 7; i++) send_byte(frame_q[i], 1'b0, 0);
        repeat (4) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        n_cmp += 6;
        if (wr_addr_q.size() != 2) begin n_bad++; $display("FAIL rst_wr_count got=%0d want=2", wr_addr_q.size()); end
        if (MEM_ADDR !== 16'h0 || MEM_DATA !== 16'h0) begin n_bad++; $display("FAIL rst_addr_data got=%h/%h want=0/0", MEM_ADDR, MEM_DATA); end
        if (CPU_RST !== 1'b1) begin n_bad++; $display("FAIL rst_cpu_rst got=%b want=1", CPU_RST); end
        if (BUSY !== 1'b0)    begin n_bad++; $display("FAIL rst_busy got=%b want=0", BUSY); end
        if (DONE !== 1'b0)    begin n_bad++; $display("FAIL rst_done got=%b want=0", DONE); end
        if (ERR !== 1'b0)     begin n_bad++; $display("FAIL rst_err got=%b want=0", ERR); end
        $display("reset mid-load after 2 words: writes=%0d", wr_addr_q.size());
        repeat (4) @(negedge CLK);
        make_frame(4, 1'b0);
        clear_writes();
        send_frame();
        n_cmp += 3;
        if (wr_addr_q.size() != 4) begin n_bad++; $display("FAIL rst_reload_count got=%0d want=4", wr_addr_q.size()); end
        else if (wr_addr_q[0] !== 16'h0 || wr_data_q[0] !== model_words[0])
            begin n_bad++; $display("FAIL rst_reload_first got=%h/%h want=0000/%h", wr_addr_q[0], wr_data_q[0], model_words[0]); end
        if (DONE !== 1'b1) begin n_bad++; $display("FAIL rst_reload_done got=%b want=1", DONE); end
        $display("reload after reset: writes=%0d done=%b", wr_addr_q.size(), DONE);
    endtask

    task automatic test_timeout();
        send_byte(8'hA5, 1'b0, 0);
        send_byte(8'h00, 1'b0, 0);
        send_byte(8'h03, 1'b0, 0);
        repeat (150) @(negedge CLK);
        n_cmp += 2;
        if (ERR !== 1'b0)  begin n_bad++; $display("FAIL tmo_early_err got=%b want=0", ERR); end
        if (BUSY !== 1'b1) begin n_bad++; $display("FAIL tmo_early_busy got=%b want=1", BUSY); end
        repeat (110) @(negedge CLK);
`ifdef TINY16_LOADER_TIMEOUT_EN
        n_cmp += 3;
        if (ERR !== 1'b1)     begin n_bad++; $display("FAIL tmo_err got=%b want=1", ERR); end
        if (BUSY !== 1'b0)    begin n_bad++; $display("FAIL tmo_busy got=%b want=0", BUSY); end
        if (CPU_RST !== 1'b1) begin n_bad++; $display("FAIL tmo_cpu_rst got=%b want=1", CPU_RST); end
`else
        n_cmp += 2;
        if (BUSY !== 1'b1) begin n_bad++; $display("FAIL tmo_busy got=%b want=1", BUSY); end
        if (ERR !== 1'b0)  begin n_bad++; $display("FAIL tmo_err got=%b want=0", ERR); end
`endif
        $display("stalled after length: busy=%b err=%b", BUSY, ERR);
    endtask

    initial begin
        @(negedge CLK);
        test_reset();
        test_directed_stream(8'hC6, 1'b1);
        test_directed_stream(8'h00, 1'b0);
        test_directed_stream(8'hC6, 1'b1);
        test_zero_len(8'h00, 1'b1);
        test_zero_len(8'h01, 1'b0);
        test_random_frames();
        test_framing_error();
        test_rst_midload();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tiny16_loader.md
Name: tiny16_loader

Overview:
- Serial program loader for tiny16; the writing end of the program-memory interface that the CPU reads.
- Receives a framed program image over a UART line and writes it word-by-word into program memory from address 0.
- Holds the CPU in reset until a load completes with a valid checksum, so the system boots without simulation-time memory preloading.

Parameters:
- CLKS_PER_BIT, 104, CLK cycles per UART bit (8N1); must be ≥4.
- ADDR_W, 16, width of MEM_ADDR; word addresses wrap modulo 2^ADDR_W.
- SYNC_BYTE, 8'hA5, byte that starts a load.
- TIMEOUT_CYCLES, 1000000, inter-byte timeout; used only with the optional feature.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous active-high reset
- RX  in  1  UART receive line, idle high, asynchronous to CLK
- MEM_WE  out  1  one-cycle write strobe to program memory
- MEM_ADDR  out  ADDR_W  write word address
- MEM_DATA  out  16  write data word
- CPU_RST  out  1  reset to the CPU core, active high
- BUSY  out  1  load in progress
- DONE  out  1  last load succeeded; sticky
- ERR  out  1  last load failed; sticky

Behaviour:
- Single clock CLK; RST is synchronous and active-high. Reset values: MEM_WE=0, MEM_ADDR=0, MEM_DATA=0, CPU_RST=1, BUSY=0, DONE=0, ERR=0; FSM in IDLE.
- RX passes through a 2-FF synchroniser.
- UART receiver (8N1, LSB first):
  - A falling edge starts a byte; the start bit is re-checked at mid-bit and, if high, treated as a glitch and ignored.
  - Data bits are sampled at mid-bit.
  - The stop bit is sampled at mid-bit; if low, a one-cycle framing-error pulse is raised. Otherwise a one-cycle byte-valid pulse is raised with the byte.
- Frame format: SYNC, LEN_HI, LEN_LO, then N words (each sent hi byte then lo byte), then CHK. CHK is the XOR of all data bytes only.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK.
  - IDLE: on SYNC_BYTE go to LEN_HI, set CPU_RST=1, BUSY=1, DONE=0, ERR=0, clear the checksum accumulator and word index. All other bytes are ignored.
  - LEN_HI → LEN_LO: latch N[15:8], then N[7:0].
  - After LEN_LO: if N=0 go to CHECK, else go to DATA_HI.
  - DATA_HI: latch the hi byte.
  - DATA_LO: MEM_WE=1 for exactly one cycle, the cycle after the lo byte's valid pulse, with MEM_DATA={hi,lo} and MEM_ADDR=index[ADDR_W-1:0]. Increment the index. If index reaches N go to CHECK, else go to DATA_HI.
  - CHECK: if received CHK equals the accumulator: DONE=1, CPU_RST=0. Otherwise: ERR=1, CPU_RST stays 1. BUSY=0 in both cases; go to IDLE.
- A framing error in any non-IDLE state: ERR=1, BUSY=0, CPU_RST=1, go to IDLE. Memory already written is left as-is.
- Re-load: a SYNC_BYTE received in IDLE after DONE reasserts CPU_RST on the next cycle and starts a new load.
- MEM_ADDR and MEM_DATA hold their last values when MEM_WE=0.
- RST mid-load aborts immediately to reset values; no partial write strobe is issued.

Optional Feature:
- Macro: TINY16_LOADER_TIMEOUT_EN.
- Defined: a counter, cleared on every byte-valid pulse, runs while BUSY. If it reaches TIMEOUT_CYCLES, set ERR=1, BUSY=0, CPU_RST=1 and go to IDLE.
- Undefined: no counter; the loader waits indefinitely for the next byte.

Decomposition:
- Package tiny16_loader_pkg holds:
  - the state enum;
  - SYNC_BYTE default;
  - the frame byte-order constants.
- Sub-module tiny16_uart_rx contains the synchroniser, bit timing and framing check.
  - Parameter: CLKS_PER_BIT.
  - Outputs: byte[7:0], byte_valid, frame_err.

Test Plan:
(All scenarios use CLKS_PER_BIT=4.)
- Send A5 00 04 15 01 17 02 34 30 C0 03 C6 -> four MEM_WE pulses: addr0=1501, addr1=1702, addr2=3430, addr3=C003; then DONE=1, CPU_RST=0, ERR=0.
- Same stream with CHK=00 -> four writes, ERR=1, CPU_RST=1, DONE=0. Then resend the valid stream -> DONE=1, CPU_RST=0.
- Send A5 00 00 00 -> no MEM_WE, DONE=1, CPU_RST=0. Send A5 00 00 01 -> ERR=1.
- Valid header, then a byte with stop bit=0 during word 2 -> exactly 1 write (addr0), ERR=1, BUSY=0. Garbage bytes before a later A5 are ignored.
- Assert RST for 1 cycle after 2 words of a 4-word load -> all outputs at reset values. Next full valid stream writes from addr0 and ends DONE=1.
- With TINY16_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=200: stop after LEN_LO -> ERR=1 at cycle 200 after the last byte-valid pulse. Without the macro: BUSY stays 1.
